// File: rtl/img_pkg.sv
// Shared constants and types for the image pipeline blocks.
// Provides pixel width, default line geometry and the row-history state.
package img_pkg;

    localparam int PIX_W        = 8;
    localparam int H_ACTIVE_DEF = 640;
    localparam int ADDR_W_DEF   = 10;

    // How many previous lines of the current frame are valid history.
    typedef enum logic [1:0] {
        ROW_0    = 2'd0,
        ROW_1    = 2'd1,
        ROW_FULL = 2'd2
    } row_e;

    function automatic row_e row_next(input row_e r);
        case (r)
            ROW_0:   return ROW_1;
            default: return ROW_FULL;
        endcase
    endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port line-buffer RAM with one-cycle registered read.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_addr/rd_data read side.
module line_buf_ram #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/matrix_3x3_gen.sv
// Builds a 3x3 pixel neighbourhood from a raster stream, 2-clk latency.
// In: video_clk, rst_n, per_de/per_vs/per_data. Out: matrix_de/vs, matrix11..33.
module matrix_3x3_gen
    import img_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int DATA_W   = PIX_W,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic              per_de,
    input  logic              per_vs,
    input  logic [DATA_W-1:0] per_data,
    output logic              matrix_de,
    output logic              matrix_vs,
    output logic [DATA_W-1:0] matrix11,
    output logic [DATA_W-1:0] matrix12,
    output logic [DATA_W-1:0] matrix13,
    output logic [DATA_W-1:0] matrix21,
    output logic [DATA_W-1:0] matrix22,
    output logic [DATA_W-1:0] matrix23,
    output logic [DATA_W-1:0] matrix31,
    output logic [DATA_W-1:0] matrix32,
    output logic [DATA_W-1:0] matrix33
);

    // One extra bit so the count can sit at H_ACTIVE on long lines.
    localparam logic [ADDR_W:0] COL_MAX = (ADDR_W+1)'(H_ACTIVE);
    localparam logic [ADDR_W:0] COL_TWO = (ADDR_W+1)'(2);

    logic [ADDR_W:0]     col_cnt;
    row_e                row_cnt;
    logic                skip_inc;
    logic                de_d1;
    logic                vs_d1;
    logic [DATA_W-1:0]   pix_d1;
    logic [ADDR_W:0]     col_d1;
    row_e                row_d1;
    logic [2*DATA_W-1:0] rd_word;
    logic [ADDR_W-1:0]   rd_addr;
    logic                ovl;
    logic                ovl_d1;
    logic                vs_rise;
    logic                de_fall;

    assign ovl     = (col_cnt == COL_MAX);
    assign ovl_d1  = (col_d1 == COL_MAX);
    assign vs_rise = per_vs & ~vs_d1;
    assign de_fall = ~per_de & de_d1;
    // Past the end of the buffer the read data is masked anyway.
    assign rd_addr = ovl ? '0 : col_cnt[ADDR_W-1:0];

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= ROW_0;
            skip_inc <= 1'b0;
            de_d1    <= 1'b0;
            vs_d1    <= 1'b0;
            pix_d1   <= '0;
            col_d1   <= '0;
            row_d1   <= ROW_0;
        end else begin
            de_d1  <= per_de;
            vs_d1  <= per_vs;
            pix_d1 <= per_data;
            col_d1 <= col_cnt;
            row_d1 <= row_cnt;
            if (per_de)
                col_cnt <= ovl ? col_cnt : col_cnt + 1'b1;
            else if (de_d1)
                col_cnt <= '0;
            // A frame start inside a line must not let that
            // line's end bump the new frame past row 0.
            if (vs_rise) begin
                row_cnt  <= ROW_0;
                skip_inc <= per_de;
            end else if (de_fall) begin
                if (skip_inc)
                    skip_inc <= 1'b0;
                else
                    row_cnt <= row_next(row_cnt);
            end
        end
    end

    // Row shift: old r-1 moves to the r-2 slot, new pixel becomes r-1.
    line_buf_ram #(
        .DEPTH  (H_ACTIVE),
        .WIDTH  (2*DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (video_clk),
        .wr_en   (de_d1 & ~ovl_d1),
        .wr_addr (col_d1[ADDR_W-1:0]),
        .wr_data ({pix_d1, rd_word[2*DATA_W-1:DATA_W]}),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    logic [DATA_W-1:0] n1, n2, n3;
    logic [DATA_W-1:0] w1_a, w1_b, w2_a, w2_b, w3_a, w3_b;
    logic              z_r2, z_r1, z_c2, z_c1;

    assign n1   = rd_word[DATA_W-1:0];
    assign n2   = rd_word[2*DATA_W-1:DATA_W];
    assign n3   = pix_d1;
    assign z_r2 = ovl_d1 | (row_d1 != ROW_FULL);
    assign z_r1 = ovl_d1 | (row_d1 == ROW_0);
    assign z_c2 = (col_d1 < COL_TWO);
    assign z_c1 = (col_d1 == '0);

    // w*_a holds column c-1, w*_b column c-2, unmasked; masking
    // happens only on the way into the output registers.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_de <= 1'b0;
            matrix_vs <= 1'b0;
            matrix11  <= '0;
            matrix12  <= '0;
            matrix13  <= '0;
            matrix21  <= '0;
            matrix22  <= '0;
            matrix23  <= '0;
            matrix31  <= '0;
            matrix32  <= '0;
            matrix33  <= '0;
            w1_a      <= '0;
            w1_b      <= '0;
            w2_a      <= '0;
            w2_b      <= '0;
            w3_a      <= '0;
            w3_b      <= '0;
        end else begin
            matrix_de <= de_d1;
            matrix_vs <= vs_d1;
            if (de_d1) begin
                matrix11 <= (z_r2 | z_c2) ? '0 : w1_b;
                matrix12 <= (z_r2 | z_c1) ? '0 : w1_a;
                matrix13 <= z_r2 ? '0 : n1;
                matrix21 <= (z_r1 | z_c2) ? '0 : w2_b;
                matrix22 <= (z_r1 | z_c1) ? '0 : w2_a;
                matrix23 <= z_r1 ? '0 : n2;
                matrix31 <= z_c2 ? '0 : w3_b;
                matrix32 <= z_c1 ? '0 : w3_a;
                matrix33 <= n3;
                w1_b     <= w1_a;
                w1_a     <= n1;
                w2_b     <= w2_a;
                w2_a     <= n2;
                w3_b     <= w3_a;
                w3_a     <= n3;
            end
        end
    end

endmodule
